// File: rtl/alu_pkg.sv
// Shared constants for the RV32 integer ALU: default width and opcode map.
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 32;

  localparam logic [7:0] OP_ALU_ADD = 8'h00;
  localparam logic [7:0] OP_ALU_SUB = 8'h01;
  localparam logic [7:0] OP_ALU_AND = 8'h02;
  localparam logic [7:0] OP_ALU_OR  = 8'h03;
  localparam logic [7:0] OP_ALU_XOR = 8'h04;
  localparam logic [7:0] OP_ALU_INV = 8'h05;
  localparam logic [7:0] OP_ALU_SLT = 8'h06;
  localparam logic [7:0] OP_ALU_SLL = 8'h07;
  localparam logic [7:0] OP_ALU_SRL = 8'h08;
  localparam logic [7:0] OP_ALU_SRA = 8'h09;
  localparam logic [7:0] OP_ALU_MUL = 8'h0A;
  localparam logic [7:0] OP_ALU_DIV = 8'h0B;
  localparam logic [7:0] OP_ALU_MOD = 8'h0C;

endpackage

// File: rtl/alu_divider.sv
// Combinational signed divide/remainder with RISC-V M corner-case results.
module alu_divider
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_quot,
  output logic [DATA_WIDTH-1:0] o_rem,
  output logic                  o_div0
);

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] ZERO     = {DATA_WIDTH{1'b0}};

  logic                  div0_s;
  logic                  ovf_s;
  logic [DATA_WIDTH-1:0] safe_b_s;
  logic [DATA_WIDTH-1:0] raw_quot_s;
  logic [DATA_WIDTH-1:0] raw_rem_s;

  // Detect the two corner cases; the raw divider never sees a zero or overflowing divisor.
  always_comb begin
    div0_s   = (i_b == ZERO);
    ovf_s    = (i_a == MOST_NEG) && (i_b == ALL_ONES);
    if (div0_s || ovf_s) begin
      safe_b_s = ONE;
    end else begin
      safe_b_s = i_b;
    end
  end

  // Signed truncating divide; remainder sign follows the dividend.
  always_comb begin
    raw_quot_s = $unsigned($signed(i_a) / $signed(safe_b_s));
    raw_rem_s  = $unsigned($signed(i_a) % $signed(safe_b_s));
  end

  // Substitute the architecturally defined results for the corner cases.
  always_comb begin
    o_div0 = div0_s;
    if (div0_s) begin
      o_quot = ALL_ONES;
      o_rem  = i_a;
    end else if (ovf_s) begin
      o_quot = MOST_NEG;
      o_rem  = ZERO;
    end else begin
      o_quot = raw_quot_s;
      o_rem  = raw_rem_s;
    end
  end

endmodule

// File: rtl/alu_core.sv
// RV32 integer ALU: zero-latency result/flags plus a registered copy.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            i_alu_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_c,
  output logic                  o_zero,
  output logic                  o_div0,
  output logic [DATA_WIDTH-1:0] o_c_q,
  output logic                  o_zero_q
);

  localparam int SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0]        shamt_s;
  logic [DATA_WIDTH-1:0] quot_s;
  logic [DATA_WIDTH-1:0] rem_s;
  logic                  div0_raw_s;
  logic [DATA_WIDTH-1:0] c_d;
  logic                  zero_d;
  logic                  div0_d;

  assign shamt_s = i_b[SHW-1:0];

  alu_divider #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_divider (
    .i_a   (i_a),
    .i_b   (i_b),
    .o_quot(quot_s),
    .o_rem (rem_s),
    .o_div0(div0_raw_s)
  );

  // Opcode decode and result select; unknown opcodes yield zero.
  always_comb begin
    c_d    = {DATA_WIDTH{1'b0}};
    div0_d = 1'b0;
    case (i_alu_op)
      OP_ALU_ADD: c_d = i_a + i_b;
      OP_ALU_SUB: c_d = i_a - i_b;
      OP_ALU_AND: c_d = i_a & i_b;
      OP_ALU_OR:  c_d = i_a | i_b;
      OP_ALU_XOR: c_d = i_a ^ i_b;
      OP_ALU_INV: c_d = ~i_a;
      OP_ALU_SLT: c_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_ALU_SLL: c_d = i_a << shamt_s;
      OP_ALU_SRL: c_d = i_a >> shamt_s;
      OP_ALU_SRA: c_d = $unsigned($signed(i_a) >>> shamt_s);
      OP_ALU_MUL: c_d = i_a * i_b;
      OP_ALU_DIV: begin
        c_d    = quot_s;
        div0_d = div0_raw_s;
      end
      OP_ALU_MOD: begin
        c_d    = rem_s;
        div0_d = div0_raw_s;
      end
      default: c_d = {DATA_WIDTH{1'b0}};
    endcase
    zero_d = (c_d == {DATA_WIDTH{1'b0}});
  end

  assign o_c    = c_d;
  assign o_zero = zero_d;
  assign o_div0 = div0_d;

  // Registered copy of the result and zero flag for downstream stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_c_q    <= {DATA_WIDTH{1'b0}};
      o_zero_q <= 1'b0;
    end else begin
      o_c_q    <= c_d;
      o_zero_q <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core.
module tb_alu_core;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  i_alu_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic [31:0] o_c;
  logic        o_zero;
  logic        o_div0;
  logic [31:0] o_c_q;
  logic        o_zero_q;

  int n_checks = 0;
  int n_fail   = 0;

  alu_core #(.DATA_WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_alu_op(i_alu_op),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_c     (o_c),
    .o_zero  (o_zero),
    .o_div0  (o_div0),
    .o_c_q   (o_c_q),
    .o_zero_q(o_zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Apply one vector mid-cycle and check the combinational result.
  task automatic vec(input string tag, input logic [7:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk);
    i_alu_op = op;
    i_a      = a;
    i_b      = b;
    #1;
    check_eq(tag, o_c, exp);
  endtask

  initial begin
    rst_n    = 1'b0;
    i_alu_op = OP_ALU_ADD;
    i_a      = 32'h0;
    i_b      = 32'h0;
    #2;
    check_eq("reset_c_q", o_c_q, 32'h0);
    check_eq("reset_zero_q", {31'h0, o_zero_q}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    vec("add", OP_ALU_ADD, 32'h1, 32'h1, 32'h2);
    vec("sub", OP_ALU_SUB, 32'h1, 32'h1, 32'h0);
    check_eq("sub_zero", {31'h0, o_zero}, 32'h1);
    vec("and", OP_ALU_AND, 32'h1001, 32'h100001, 32'h1);
    check_eq("and_zero", {31'h0, o_zero}, 32'h0);
    vec("or",  OP_ALU_OR,  32'h101, 32'h10001, 32'h10101);
    vec("xor", OP_ALU_XOR, 32'h101, 32'h10001, 32'h10100);
    vec("inv", OP_ALU_INV, 32'h1, 32'hDEADBEEF, 32'hFFFFFFFE);

    vec("slt_pos", OP_ALU_SLT, 32'h101, 32'h10001, 32'h1);
    vec("slt_neg", OP_ALU_SLT, 32'hFFFFFFFF, 32'h1, 32'h1);
    vec("slt_ge",  OP_ALU_SLT, 32'h1, 32'hFFFFFFFF, 32'h0);
    vec("sll",     OP_ALU_SLL, 32'h1, 32'h10, 32'h10000);
    vec("srl",     OP_ALU_SRL, 32'h100, 32'h1, 32'h80);
    vec("srl_by0", OP_ALU_SRL, 32'h80000001, 32'h0, 32'h80000001);
    vec("srl_msb", OP_ALU_SRL, 32'h80000000, 32'h1F, 32'h1);
    vec("sra",     OP_ALU_SRA, 32'hFFFFFFF0, 32'h3, 32'hFFFFFFFE);
    vec("sra_31",  OP_ALU_SRA, 32'h80000000, 32'h1F, 32'hFFFFFFFF);
    vec("sra_pos", OP_ALU_SRA, 32'h40000000, 32'h2, 32'h10000000);
    vec("sll_wrap", OP_ALU_SLL, 32'h1, 32'h21, 32'h2);

    vec("mul",      OP_ALU_MUL, 32'h2, 32'h2, 32'h4);
    vec("mul_neg",  OP_ALU_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1);
    vec("div",      OP_ALU_DIV, 32'h5, 32'h5, 32'h1);
    check_eq("div_nodiv0", {31'h0, o_div0}, 32'h0);
    vec("mod",      OP_ALU_MOD, 32'h7, 32'h5, 32'h2);
    vec("div_neg",  OP_ALU_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD);
    vec("mod_neg",  OP_ALU_MOD, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF);
    vec("div_pn",   OP_ALU_DIV, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD);
    vec("mod_pn",   OP_ALU_MOD, 32'h7, 32'hFFFFFFFE, 32'h1);

    vec("div0",     OP_ALU_DIV, 32'h9, 32'h0, 32'hFFFFFFFF);
    check_eq("div0_flag", {31'h0, o_div0}, 32'h1);
    vec("mod0",     OP_ALU_MOD, 32'h9, 32'h0, 32'h9);
    check_eq("mod0_flag", {31'h0, o_div0}, 32'h1);
    vec("add_b0_nodiv0", OP_ALU_ADD, 32'h9, 32'h0, 32'h9);
    check_eq("add_b0_flag", {31'h0, o_div0}, 32'h0);
    vec("div_ovf",  OP_ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    check_eq("div_ovf_flag", {31'h0, o_div0}, 32'h0);
    vec("mod_ovf",  OP_ALU_MOD, 32'h80000000, 32'hFFFFFFFF, 32'h0);

    vec("undef_op", 8'hFF, 32'h12345678, 32'h9ABCDEF0, 32'h0);
    check_eq("undef_zero", {31'h0, o_zero}, 32'h1);
    vec("op_0d",    8'h0D, 32'h1, 32'h1, 32'h0);

    // Registered path and asynchronous reset.
    vec("add_reg", OP_ALU_ADD, 32'h3, 32'h4, 32'h7);
    @(posedge clk);
    #1;
    check_eq("c_q_after_edge", o_c_q, 32'h7);
    check_eq("zero_q_after_edge", {31'h0, o_zero_q}, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("c_q_async_rst", o_c_q, 32'h0);
    check_eq("c_during_rst", o_c, 32'h7);
    @(posedge clk);
    #1;
    check_eq("c_q_held_rst", o_c_q, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("c_q_after_release", o_c_q, 32'h7);

    vec("sub_reg", OP_ALU_SUB, 32'h5, 32'h5, 32'h0);
    @(posedge clk);
    #1;
    check_eq("zero_q_set", {31'h0, o_zero_q}, 32'h1);
    check_eq("c_q_zero", o_c_q, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
